// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle RV32I OP/OP-IMM execute sequencer driving regfile reads, ALU controls and writeback
module alu_exec_ctrl #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  input  logic [31:0] instr_in,
  output logic [4:0]  rs1_addr_out,
  output logic [4:0]  rs2_addr_out,
  output logic        imm_sel_out,
  output logic [11:0] imm_value_out,
  output logic [3:0]  alu_op_out,
  input  logic [31:0] alu_result_in,
  output logic        rd_we_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_data_out,
  output logic        illegal_out,
  output logic        busy_out
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, TRAP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d, rd_data_q, rd_data_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [2:0]  in_f3;
  logic [6:0]  in_f7;
  logic        legal, accept, last, in_ex, is_opi;
  assign in_f3 = instr_in[14:12];
  assign in_f7 = instr_in[31:25];
  assign legal = instr_in[6:0] == 7'b0110011 ? (in_f7 == 7'h00 || (in_f7 == 7'h20 && (in_f3 == 3'b000 || in_f3 == 3'b101))) :
                 instr_in[6:0] == 7'b0010011 ? (in_f3 == 3'b001 ? in_f7 == 7'h00 :
                                                in_f3 == 3'b101 ? (in_f7 == 7'h00 || in_f7 == 7'h20) : 1'b1) : 1'b0;
  assign instr_ready_out = rst_n_in && state_q == IDLE;
  assign accept = instr_valid_in && instr_ready_out;
  assign last = cnt_q == 4'(ALU_LAT - 1);
  assign in_ex = state_q == EXEC;
  assign is_opi = instr_q[6:0] == 7'b0010011;
  always_comb begin
    instr_d = accept ? instr_in : instr_q;
    state_d = state_q == IDLE ? (accept ? (legal ? READ : TRAP) : IDLE) :
              state_q == READ ? EXEC :
              state_q == EXEC ? (last ? WB : EXEC) : IDLE;
    cnt_d = in_ex && !last ? cnt_q + 4'd1 : 4'd0;
    rd_data_d = in_ex && last ? alu_result_in : rd_data_q;
    rd_addr_d = in_ex && last ? instr_q[11:7] : rd_addr_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      instr_q <= '0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      instr_q <= instr_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end
  assign rs1_addr_out = state_q == READ || in_ex ? instr_q[19:15] : '0;
  assign rs2_addr_out = state_q == READ || in_ex ? instr_q[24:20] : '0;
  assign imm_sel_out = in_ex && is_opi;
  assign imm_value_out = imm_sel_out ? instr_q[31:20] : '0;
  assign alu_op_out = in_ex ? {instr_q[30] && (!is_opi || instr_q[14:12] == 3'b101), instr_q[14:12]} : '0;
  assign rd_we_out = state_q == WB && rd_addr_q != 5'd0;
  assign rd_addr_out = rd_addr_q;
  assign rd_data_out = rd_data_q;
  assign illegal_out = state_q == TRAP;
  assign busy_out = state_q != IDLE;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: randomized scoreboard bench for alu_exec_ctrl against a behavioural decode model
module tb_alu_exec_ctrl;
  localparam int L = 3;
  bit          clk;
  logic        rst_n_in, instr_valid_in, instr_ready_out, imm_sel_out, rd_we_out, illegal_out, busy_out;
  logic [31:0] instr_in, alu_result_in, rd_data_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
  logic [11:0] imm_value_out;
  logic [3:0]  alu_op_out;
  alu_exec_ctrl #(.ALU_LAT(L)) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .instr_in(instr_in), .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out), .imm_sel_out(imm_sel_out),
    .imm_value_out(imm_value_out), .alu_op_out(alu_op_out), .alu_result_in(alu_result_in), .rd_we_out(rd_we_out),
    .rd_addr_out(rd_addr_out), .rd_data_out(rd_data_out), .illegal_out(illegal_out), .busy_out(busy_out)
  );
  typedef struct {
    logic        legal;
    logic [4:0]  rs1, rs2, rd;
    logic        imm_sel;
    logic [11:0] imm;
    logic [3:0]  op;
    logic        we;
  } exp_t;
  typedef struct {
    int          acc;
    logic [31:0] instr;
  } txn_t;
  txn_t        sb[$];
  logic [31:0] res_hist[int];
  int          cyc, compared, failed;
  bit          edge_rst;
  logic [4:0]  last_a;
  logic [31:0] last_d;
  txn_t        mon_h;
  exp_t        mon_e;
  int          mon_p;
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    edge_rst = rst_n_in;
    cyc = cyc + 1;
    #1;
    alu_result_in = $urandom;
    res_hist[cyc] = alu_result_in;
  end
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    logic op, opi;
    f7 = w[31:25];
    f3 = w[14:12];
    op = w[6:0] == 7'b0110011;
    opi = w[6:0] == 7'b0010011;
    e.legal = 1'b0;
    if (op) e.legal = f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (opi) e.legal = f3 == 3'd1 ? f7 == 7'd0 : f3 == 3'd5 ? (f7 == 7'd0 || f7 == 7'h20) : 1'b1;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd = w[11:7];
    e.imm_sel = opi;
    e.imm = opi ? w[31:20] : 12'd0;
    e.op = {(op || f3 == 3'd5) && w[30], f3};
    e.we = w[11:7] != 5'd0;
    return e;
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [31:0] w, r;
    int k;
    w = $urandom;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3) begin
      w[6:0] = 7'b0110011;
      w[31:25] = (w[14:12] == 3'd0 || w[14:12] == 3'd5) && r[0] ? 7'h20 : 7'h00;
    end else if (k <= 6) begin
      w[6:0] = 7'b0010011;
      if (w[14:12] == 3'd1) w[31:25] = 7'h00;
      if (w[14:12] == 3'd5) w[31:25] = r[0] ? 7'h20 : 7'h00;
    end else if (k == 7) begin
      w[6:0] = 7'b0110011;
    end else if (k == 8) begin
      w[6:0] = 7'b0010011;
      w[14:12] = r[1] ? 3'd5 : 3'd1;
    end
    if (r[4:2] == 3'd0) w[11:7] = 5'd0;
    return w;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    compared++;
    if (a !== x) begin
      failed++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, a, x, cyc);
    end
  endtask
  task automatic send(input logic [31:0] w, output int acc);
    int n;
    n = 0;
    acc = -1;
    instr_in = w;
    instr_valid_in = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_ready_out && n < 40);
    compared++;
    if (!instr_ready_out) begin
      failed++;
      $display("FAIL accept_timeout: ready stayed %b, required 1 within 40 cycles", instr_ready_out);
      instr_valid_in = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back('{acc: cyc, instr: w});
    instr_in = $urandom;
    instr_valid_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    instr_valid_in = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!edge_rst) begin
      sb.delete();
      last_a = '0;
      last_d = '0;
      chk("rst_ready", 32'(instr_ready_out), 32'(rst_n_in));
      chk("rst_busy", 32'(busy_out), 0);
      chk("rst_rs1", 32'(rs1_addr_out), 0);
      chk("rst_rs2", 32'(rs2_addr_out), 0);
      chk("rst_imm_sel", 32'(imm_sel_out), 0);
      chk("rst_imm", 32'(imm_value_out), 0);
      chk("rst_alu_op", 32'(alu_op_out), 0);
      chk("rst_rd_we", 32'(rd_we_out), 0);
      chk("rst_rd_addr", 32'(rd_addr_out), 0);
      chk("rst_rd_data", rd_data_out, 0);
      chk("rst_illegal", 32'(illegal_out), 0);
    end else if (sb.size() == 0) begin
      chk("idle_ready", 32'(instr_ready_out), 32'(rst_n_in));
      if (rst_n_in) begin
        chk("idle_busy", 32'(busy_out), 0);
        chk("idle_rd_we", 32'(rd_we_out), 0);
        chk("idle_illegal", 32'(illegal_out), 0);
        chk("idle_rs1", 32'(rs1_addr_out), 0);
        chk("idle_rs2", 32'(rs2_addr_out), 0);
        chk("idle_imm_sel", 32'(imm_sel_out), 0);
        chk("idle_imm", 32'(imm_value_out), 0);
        chk("idle_alu_op", 32'(alu_op_out), 0);
        chk("hold_rd_addr", 32'(rd_addr_out), 32'(last_a));
        chk("hold_rd_data", rd_data_out, last_d);
      end
    end else begin
      mon_h = sb[0];
      mon_e = model(mon_h.instr);
      mon_p = cyc - mon_h.acc;
      chk("busy_ready", 32'(instr_ready_out), 0);
      chk("busy_busy", 32'(busy_out), 1);
      if (!mon_e.legal) begin
        chk("trap_lat", 32'(mon_p), 0);
        chk("trap_illegal", 32'(illegal_out), 1);
        chk("trap_rd_we", 32'(rd_we_out), 0);
        chk("trap_rs1", 32'(rs1_addr_out), 0);
        chk("trap_imm_sel", 32'(imm_sel_out), 0);
        chk("trap_alu_op", 32'(alu_op_out), 0);
        chk("trap_rd_addr", 32'(rd_addr_out), 32'(last_a));
        chk("trap_rd_data", rd_data_out, last_d);
        void'(sb.pop_front());
      end else if (mon_p <= L) begin
        chk("rd_rs1", 32'(rs1_addr_out), 32'(mon_e.rs1));
        chk("rd_rs2", 32'(rs2_addr_out), 32'(mon_e.rs2));
        chk("ex_imm_sel", 32'(imm_sel_out), mon_p == 0 ? 0 : 32'(mon_e.imm_sel));
        chk("ex_imm", 32'(imm_value_out), mon_p == 0 ? 0 : 32'(mon_e.imm));
        chk("ex_alu_op", 32'(alu_op_out), mon_p == 0 ? 0 : 32'(mon_e.op));
        chk("ex_rd_we", 32'(rd_we_out), 0);
        chk("ex_illegal", 32'(illegal_out), 0);
      end else begin
        chk("wb_lat", 32'(mon_p), 32'(L + 1));
        chk("wb_rd_we", 32'(rd_we_out), 32'(mon_e.we));
        chk("wb_rd_addr", 32'(rd_addr_out), 32'(mon_e.rd));
        chk("wb_rd_data", rd_data_out, res_hist[mon_h.acc + L]);
        chk("wb_rs1", 32'(rs1_addr_out), 0);
        chk("wb_alu_op", 32'(alu_op_out), 0);
        chk("wb_illegal", 32'(illegal_out), 0);
        last_a = mon_e.rd;
        last_d = res_hist[mon_h.acc + L];
        void'(sb.pop_front());
      end
    end
  end
  initial begin
    logic [31:0] dir[7];
    int acc, n;
    dir = '{32'hFFD08293, 32'h402081B3, 32'h40435393, 32'h00000073, 32'h40109093, 32'h00208033, 32'h40008093};
    rst_n_in = 1'b0;
    instr_valid_in = 1'b0;
    instr_in = '0;
    alu_result_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n_in = 1'b1;
    foreach (dir[i]) send(dir[i], acc);
    send(32'h40435393, acc);
    @(posedge clk);
    #1;
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_in = 1'b1;
    send(32'h00A00513, acc);
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(rand_instr(), acc);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    compared++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d transactions outstanding, required 0", sb.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Multi-cycle execute sequencer for the single-cycle-shared ALU path.
- Accepts one decoded-later instruction word per transaction via valid/ready, drives register-file read addresses, ALU operand-mux select, 12-bit immediate and ALU opcode, waits a configurable ALU latency, then issues one register writeback.
- Handles RV32I OP (0110011) and OP-IMM (0010011) only; all other encodings are trapped as illegal.

Parameters:
- ALU_LAT, 1, number of EXEC cycles before alu_result_in is sampled (legal 1..15).

Ports:
- clk_in  input  1  clock, all state on rising edge
- rst_n_in  input  1  reset, synchronous, active-low
- instr_valid_in  input  1  instruction word valid
- instr_ready_out  output  1  controller can accept instruction
- instr_in  input  32  RV32I instruction word
- rs1_addr_out  output  5  register-file read address 1
- rs2_addr_out  output  5  register-file read address 2
- imm_sel_out  output  1  1 = ALU operand B is the sign-extended immediate, 0 = rs2
- imm_value_out  output  12  immediate for the operand mux
- alu_op_out  output  4  ALU opcode {bit30-qualifier, funct3}
- alu_result_in  input  32  ALU result
- rd_we_out  output  1  writeback enable, single-cycle pulse
- rd_addr_out  output  5  writeback register
- rd_data_out  output  32  writeback data
- illegal_out  output  1  single-cycle pulse on rejected instruction
- busy_out  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous, active-low. While rst_n_in=0 at an edge: state=IDLE, exec counter=0, instruction register=0, and all outputs are 0, including instr_ready_out, which is held 0 while rst_n_in is low.
- States are IDLE, READ, EXEC, WB, TRAP.
- IDLE:
  - instr_ready_out=1.
  - On instr_valid_in&&instr_ready_out, latch instr_in.
  - Next state is READ if legal, TRAP if illegal.
- READ (1 cycle):
  - rs1_addr_out=instr[19:15] and rs2_addr_out=instr[24:20] are driven from the latched word.
  - Both addresses are held stable through READ and EXEC, and are 0 in IDLE.
  - The register file has 1-cycle registered read.
- EXEC (ALU_LAT cycles, counter counts 0..ALU_LAT-1):
  - imm_sel_out=1 for OP-IMM, 0 for OP.
  - imm_value_out=instr[31:20] for OP-IMM, 0 for OP.
  - alu_op_out is valid and held for every EXEC cycle.
  - On the last EXEC cycle, capture alu_result_in into rd_data_out.
- WB (1 cycle): rd_we_out=1 unless rd=0, in which case rd_we_out=0 and no write occurs. rd_addr_out=instr[11:7]. Next state is IDLE.
- TRAP (1 cycle): illegal_out=1, rd_we_out=0. Next state is IDLE.
- imm_sel_out, imm_value_out and alu_op_out are 0 outside EXEC.
- rd_addr_out and rd_data_out hold their last value after WB.
- Latency: accept at edge N gives READ in cycle N+1, EXEC in cycles N+2..N+1+ALU_LAT, and the WB pulse in cycle N+2+ALU_LAT.
- Throughput is one instruction per 3+ALU_LAT cycles. The next accept is possible in the cycle after WB or TRAP.
- alu_op rules:
  - OP: {instr[30], funct3}.
  - OP-IMM: {instr[30] only when funct3=101, else 0, funct3}. ADDI with imm bit 10 set must NOT produce SUB.
- Legality rules:
  - OP: funct7=0000000 for any funct3, or funct7=0100000 only with funct3 000 or 101.
  - OP-IMM: funct3 001 requires imm[11:5]=0000000; funct3 101 requires imm[11:5] to be 0000000 or 0100000.
  - Any other opcode is illegal.
- instr_valid_in while not ready is ignored; the instruction is not consumed. instr_in changing after accept has no effect.
- Reset asserted in any state aborts the transaction: no rd_we_out and no illegal_out pulse are produced.
- The exec counter must not overflow for ALU_LAT=15.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), ALU_LAT=1, alu_result_in=0x7:
  - READ: rs1_addr=1.
  - EXEC: imm_sel=1, imm_value=0xFFD, alu_op=0000.
  - WB 3 cycles after accept: rd_we=1, rd_addr=5, rd_data=0x7.
- SUB x3,x1,x2 (0x402081B3): EXEC imm_sel=0, alu_op=1000, rs1/rs2 addr=1/2; WB rd_addr=3.
- SRAI x7,x6,4 (0x40435393), ALU_LAT=3:
  - alu_op=1101 and imm_value=0x404 held for 3 EXEC cycles.
  - Result sampled on the 3rd EXEC cycle.
  - rd_we pulses at accept+5.
- ECALL (0x00000073) and SLLI with imm[11:5]=0100000 (0x40109093): illegal_out pulses 1 cycle after accept, no rd_we, ready returns the following cycle.
- ADD x0,x1,x2 (0x00208033): full sequence runs, rd_we_out stays 0 throughout.
- ALU_LAT=3, deassert rst_n_in during the 2nd EXEC cycle: next edge gives all outputs 0, no rd_we, ready=0 while reset is low, ready=1 on the first cycle after release, and the next instruction completes normally.
